// File: rtl/conv_mac_pipe.sv
// Pipelined signed multiply-accumulate for conv layers: windowed dot products
// delimited by a last flag, optional saturation, valid/ready output with backpressure.
module conv_mac_pipe #(
  parameter int ID         = 1,
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_STAGE  = 2,
  parameter int SATURATE   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  dout,
  output logic                         overflow
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int SW = ACC_WIDTH + 1;

  if (ACC_WIDTH < PW || NUM_STAGE < 1 || ID < 0) begin : g_param_check
    $error("conv_mac_pipe: illegal parameter combination");
  end

  logic                 adv;
  logic signed [PW-1:0] prod_d;
  logic [PW-1:0]        prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0] vld_q;
  logic [NUM_STAGE-1:0] last_q;

  logic [ACC_WIDTH-1:0] acc_q;
  logic                 first_q;
  logic                 ovf_win_q;
  logic                 out_valid_q;
  logic [ACC_WIDTH-1:0] dout_q;
  logic                 overflow_q;

  logic [SW-1:0]        pext_d;
  logic [SW-1:0]        base_d;
  logic [SW-1:0]        sum_d;
  logic [ACC_WIDTH-1:0] res_d;
  logic                 ovf_term_d;
  logic                 ovf_acc_d;

  // A held result that downstream refuses stalls the entire pipe.
  assign adv      = ce & ~(out_valid_q & ~out_ready);
  assign in_ready = adv;
  assign prod_d   = din0 * din1;

  always_comb begin
    pext_d     = {{(SW-PW){prod_q[NUM_STAGE-1][PW-1]}}, prod_q[NUM_STAGE-1]};
    base_d     = first_q ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
    sum_d      = base_d + pext_d;
    // One guard bit suffices: both addends fit in ACC_WIDTH signed bits.
    ovf_term_d = sum_d[SW-1] ^ sum_d[SW-2];
    res_d      = sum_d[ACC_WIDTH-1:0];
    if (SATURATE != 0 && ovf_term_d) begin
      res_d = sum_d[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    ovf_acc_d  = (first_q ? 1'b0 : ovf_win_q) | ovf_term_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= '0;
      end
      vld_q       <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      ovf_win_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
    end else if (adv) begin
      prod_q[0] <= prod_d;
      vld_q[0]  <= in_valid;
      last_q[0] <= in_last;
      for (int unsigned i = 1; i < NUM_STAGE; i++) begin
        prod_q[i] <= prod_q[i-1];
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end

      // Consume first; a result loaded below in the same cycle overrides it.
      if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (vld_q[NUM_STAGE-1]) begin
        if (last_q[NUM_STAGE-1]) begin
          dout_q      <= res_d;
          overflow_q  <= ovf_acc_d;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          first_q     <= 1'b1;
          ovf_win_q   <= 1'b0;
        end else begin
          acc_q       <= res_d;
          first_q     <= 1'b0;
          ovf_win_q   <= ovf_acc_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign overflow  = overflow_q;

endmodule
